// File: rtl/dmi_reg_arbiter.sv
// ---------------------------------------------------------------------------
// dmi_reg_arbiter
//
// Shares the core-side debug register interface between two requesters:
//   port 0 - JTAG/DMI synchronizer output
//   port 1 - secondary debug master (e.g. system-bus debug bridge)
// Round-robin arbitration, one outstanding transaction at a time.
//
// Optional feature (compile-time macro DMI_REG_ARB_TIMEOUT_EN):
//   defined   - an ack-timeout counter ends a stuck WAIT after
//               2^TO_CNT_W-1 cycles, completing with rN_err=1, rN_rdata=0.
//   undefined - no counter; WAIT waits indefinitely; rN_err tied to 0.
//
// Handshake: a requester raises rN_req (level) with wr/addr/wdata stable and
// holds it until it samples rN_done high; it drops rN_req on that same clock
// edge. The debug module sees a one-cycle reg_en strobe and answers with a
// one-cycle reg_ack, which may arrive in the strobe cycle itself or later.
//
// Ports:
//   core_clk, core_rst            clock, async active-high reset
//   rN_req/rN_wr/rN_addr/rN_wdata requester N access request
//   rN_done/rN_rdata/rN_err       requester N completion (registered)
//   reg_en/reg_wr_en/reg_wr_addr/reg_wr_data  bus toward debug module
//   rd_data/reg_ack               response from debug module
//   busy                          high whenever the FSM is not IDLE
//   gnt                           current or last granted port
// ---------------------------------------------------------------------------
module dmi_reg_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TO_CNT_W = 8
) (
    input  logic          core_clk,
    input  logic          core_rst,

    input  logic          r0_req,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_done,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,

    input  logic          r1_req,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_done,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,

    output logic          reg_en,
    output logic          reg_wr_en,
    output logic [AW-1:0] reg_wr_addr,
    output logic [DW-1:0] reg_wr_data,
    input  logic [DW-1:0] rd_data,
    input  logic          reg_ack,

    output logic          busy,
    output logic          gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_gnt;
    logic   pick;
    logic   grant_now;
    logic   resp_ok;
    logic   to_fire;

    // On a tie the port that did not win last time gets the grant; with a
    // single requester that requester wins regardless of history.
    assign pick      = (r0_req && r1_req) ? ~last_gnt : r1_req;
    assign grant_now = (state == IDLE) && (r0_req || r1_req);
    // An ack counts only while a transaction is on the bus (ISSUE or WAIT).
    assign resp_ok   = ((state == ISSUE) || (state == WAIT)) && reg_ack;
    assign busy      = (state != IDLE);

`ifdef DMI_REG_ARB_TIMEOUT_EN
    // Counter holds k-1 in the k-th WAIT cycle, so firing on the step into
    // all-ones ends WAIT after exactly 2^TO_CNT_W-1 cycles. An ack in that
    // same cycle takes priority because to_fire requires !reg_ack.
    localparam logic [TO_CNT_W-1:0] TO_LAST = {TO_CNT_W{1'b1}} - 1'b1;
    logic [TO_CNT_W-1:0] to_cnt;

    assign to_fire = (state == WAIT) && !reg_ack && (to_cnt == TO_LAST);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if ((state == WAIT) && !reg_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r0_err <= 1'b0;
            r1_err <= 1'b0;
        end else if (resp_ok) begin
            if (gnt) r1_err <= 1'b0;
            else     r0_err <= 1'b0;
        end else if (to_fire) begin
            if (gnt) r1_err <= 1'b1;
            else     r0_err <= 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
    assign r0_err  = 1'b0;
    assign r1_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (r0_req || r1_req) next_state = ISSUE;
            ISSUE:   next_state = reg_ack ? RESP : WAIT;
            WAIT:    if (reg_ack || to_fire) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered bus and response outputs
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            reg_en      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            gnt         <= 1'b0;
            last_gnt    <= 1'b1;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            r0_rdata    <= '0;
            r1_rdata    <= '0;
        end else begin
            // reg_en is high exactly in the ISSUE cycle.
            reg_en  <= grant_now;
            r0_done <= 1'b0;
            r1_done <= 1'b0;

            // Bus fields change only on a new grant and hold until the next.
            if (grant_now) begin
                gnt         <= pick;
                reg_wr_en   <= pick ? r1_wr    : r0_wr;
                reg_wr_addr <= pick ? r1_addr  : r0_addr;
                reg_wr_data <= pick ? r1_wdata : r0_wdata;
            end

            // Completion: read data is captured for writes too.
            if (resp_ok) begin
                if (gnt) begin
                    r1_done  <= 1'b1;
                    r1_rdata <= rd_data;
                end else begin
                    r0_done  <= 1'b1;
                    r0_rdata <= rd_data;
                end
            end else if (to_fire) begin
                if (gnt) begin
                    r1_done  <= 1'b1;
                    r1_rdata <= '0;
                end else begin
                    r0_done  <= 1'b1;
                    r0_rdata <= '0;
                end
            end

            if (state == RESP) last_gnt <= gnt;
        end
    end

endmodule

// File: tb/tb_dmi_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmi_reg_arbiter
//
// Directed bench for dmi_reg_arbiter. Inputs change on the falling edge,
// outputs are observed on the falling edge, so every check sits half a
// cycle away from the active rising edge. The timeout scenario is compiled
// only when DMI_REG_ARB_TIMEOUT_EN is defined (TO_CNT_W=4 -> 15 WAIT cycles).
// ---------------------------------------------------------------------------
module tb_dmi_reg_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;

    logic          core_clk = 1'b0;
    logic          core_rst = 1'b1;
    logic          r0_req = 1'b0, r0_wr = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_done, r0_err;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_wr = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_done, r1_err;
    logic [DW-1:0] r1_rdata;
    logic          reg_en, reg_wr_en;
    logic [AW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;
    logic [DW-1:0] rd_data = '0;
    logic          reg_ack = 1'b0;
    logic          busy, gnt;

    int checks = 0;
    int errors = 0;

    dmi_reg_arbiter #(.AW(AW), .DW(DW), .TO_CNT_W(TW)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .rd_data(rd_data), .reg_ack(reg_ack),
        .busy(busy), .gnt(gnt)
    );

    // Clock
    always #5 core_clk = ~core_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (reg_en !== 1'b0) begin errors++; $display("FAIL rst_reg_en got=%b exp=0", reg_en); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
        checks++; if ({r0_done, r1_done, r0_err, r1_err} !== 4'b0) begin errors++; $display("FAIL rst_resp got=%b exp=0000", {r0_done, r1_done, r0_err, r1_err}); end
        checks++; if (reg_wr_addr !== '0 || r0_rdata !== '0 || r1_rdata !== '0) begin errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", reg_wr_addr, r0_rdata, r1_rdata); end
        core_rst = 1'b0;
        tick(1);
    endtask

    task automatic test_port0_read();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h11;
        tick(1);  // ISSUE
        checks++; if (reg_en !== 1'b1 || reg_wr_en !== 1'b0) begin errors++; $display("FAIL rd_issue got en=%b wr=%b exp en=1 wr=0", reg_en, reg_wr_en); end
        checks++; if (reg_wr_addr !== 32'h11 || gnt !== 1'b0) begin errors++; $display("FAIL rd_addr got=%h gnt=%b exp=11 gnt=0", reg_wr_addr, gnt); end
        tick(1);  // WAIT 1
        checks++; if (reg_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait got en=%b busy=%b exp en=0 busy=1", reg_en, busy); end
        tick(1);  // WAIT 2: ack two cycles after the strobe
        reg_ack = 1'b1; rd_data = 32'hCAFE_F00D;
        tick(1);  // RESP
        reg_ack = 1'b0; rd_data = '0;
        checks++; if (r0_done !== 1'b1 || r1_done !== 1'b0) begin errors++; $display("FAIL rd_done got r0=%b r1=%b exp r0=1 r1=0", r0_done, r1_done); end
        checks++; if (r0_rdata !== 32'hCAFE_F00D || r0_err !== 1'b0) begin errors++; $display("FAIL rd_data got=%h err=%b exp=cafef00d err=0", r0_rdata, r0_err); end
        checks++; if (reg_wr_addr !== 32'h11) begin errors++; $display("FAIL rd_addr_hold got=%h exp=11", reg_wr_addr); end
        r0_req = 1'b0;
        tick(1);  // IDLE
        checks++; if (r0_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_end got done=%b busy=%b exp 0/0", r0_done, busy); end
        checks++; if (r0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_hold got=%h exp=cafef00d", r0_rdata); end
    endtask

    task automatic test_port1_write();
        r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 32'h10; r1_wdata = 32'h8000_0001;
        tick(1);  // ISSUE
        checks++; if (reg_en !== 1'b1 || reg_wr_en !== 1'b1 || gnt !== 1'b1) begin errors++; $display("FAIL wr_issue got en=%b wr=%b gnt=%b exp 1/1/1", reg_en, reg_wr_en, gnt); end
        checks++; if (reg_wr_addr !== 32'h10 || reg_wr_data !== 32'h8000_0001) begin errors++; $display("FAIL wr_bus got=%h/%h exp=10/80000001", reg_wr_addr, reg_wr_data); end
        reg_ack = 1'b1; rd_data = 32'h1234_5678;  // same-cycle ack
        tick(1);  // RESP, third cycle counting the request cycle
        reg_ack = 1'b0; rd_data = '0;
        checks++; if (r1_done !== 1'b1 || r0_done !== 1'b0) begin errors++; $display("FAIL wr_done got r1=%b r0=%b exp r1=1 r0=0", r1_done, r0_done); end
        checks++; if (r1_rdata !== 32'h1234_5678 || r1_err !== 1'b0) begin errors++; $display("FAIL wr_capture got=%h err=%b exp=12345678 err=0", r1_rdata, r1_err); end
        checks++; if (r0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_other_hold got=%h exp=cafef00d", r0_rdata); end
        r1_req = 1'b0;
        tick(1);
        checks++; if (r1_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_end got done=%b busy=%b exp 0/0", r1_done, busy); end
    endtask

    task automatic test_stray_ack();
        reg_ack = 1'b1; rd_data = 32'hDEAD_0000;
        tick(2);
        reg_ack = 1'b0; rd_data = '0;
        checks++; if (busy !== 1'b0 || reg_en !== 1'b0 || r0_done !== 1'b0 || r1_done !== 1'b0) begin errors++; $display("FAIL stray_idle got busy=%b en=%b d=%b%b exp all 0", busy, reg_en, r0_done, r1_done); end
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h24;
        tick(1);
        checks++; if (reg_en !== 1'b1 || reg_wr_addr !== 32'h24) begin errors++; $display("FAIL stray_issue got en=%b addr=%h exp en=1 addr=24", reg_en, reg_wr_addr); end
        tick(1);  // WAIT
        reg_ack = 1'b1; rd_data = 32'h0BAD_BEEF;
        tick(1);  // RESP
        reg_ack = 1'b0; rd_data = '0;
        checks++; if (r0_done !== 1'b1 || r0_rdata !== 32'h0BAD_BEEF) begin errors++; $display("FAIL stray_read got done=%b data=%h exp 1/0badbeef", r0_done, r0_rdata); end
        r0_req = 1'b0;
        // A stray ack during RESP->IDLE must not restart anything.
        reg_ack = 1'b1;
        tick(1);
        reg_ack = 1'b0;
        checks++; if (busy !== 1'b0 || r0_done !== 1'b0) begin errors++; $display("FAIL stray_resp got busy=%b done=%b exp 0/0", busy, r0_done); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr;
        logic          exp_port;
        int            wait_n;
        core_rst = 1'b1;  // fresh history: port 0 wins the first tie
        tick(1);
        core_rst = 1'b0;
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h100;
        r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 32'h200; r1_wdata = 32'h5A5A_5A5A;
        for (int i = 0; i < 4; i++) begin
            exp_port = i[0];
            exp_addr = exp_port ? 32'h200 : 32'h100;
            wait_n = 0;
            tick(1);
            while (reg_en !== 1'b1 && wait_n < 4) begin tick(1); wait_n++; end
            checks++; if (reg_en !== 1'b1) begin errors++; $display("FAIL b2b_timeout txn=%0d got no reg_en exp reg_en=1", i); end
            checks++; if (gnt !== exp_port || reg_wr_addr !== exp_addr) begin errors++; $display("FAIL b2b_grant txn=%0d got gnt=%b addr=%h exp gnt=%b addr=%h", i, gnt, reg_wr_addr, exp_port, exp_addr); end
            tick(1);  // WAIT
            checks++; if (reg_en !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse txn=%0d got en=%b exp 0", i, reg_en); end
            reg_ack = 1'b1; rd_data = 32'hA000_0000 + 32'(i);
            tick(1);  // RESP
            reg_ack = 1'b0;
            checks++; if ({r1_done, r0_done} !== (exp_port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_done txn=%0d got r1r0=%b%b exp port %b", i, r1_done, r0_done, exp_port); end
            checks++; if ((exp_port ? r1_rdata : r0_rdata) !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL b2b_data txn=%0d got=%h exp=%h", i, exp_port ? r1_rdata : r0_rdata, 32'hA000_0000 + 32'(i)); end
            if (exp_port) r1_req = 1'b0; else r0_req = 1'b0;
            tick(1);  // IDLE, other port still requesting
            checks++; if (reg_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle txn=%0d got en=%b busy=%b exp 0/0", i, reg_en, busy); end
            if (i < 3) begin
                if (exp_port) r1_req = 1'b1; else r0_req = 1'b1;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h33;
        tick(3);  // ISSUE, WAIT, WAIT
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp 1", busy); end
        core_rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || reg_en !== 1'b0 || r0_done !== 1'b0) begin errors++; $display("FAIL mid_async got busy=%b en=%b done=%b exp 0/0/0", busy, reg_en, r0_done); end
        tick(2);
        checks++; if (r0_done !== 1'b0 || reg_wr_addr !== '0) begin errors++; $display("FAIL mid_held got done=%b addr=%h exp 0/0", r0_done, reg_wr_addr); end
        core_rst = 1'b0;
        tick(1);  // held request re-granted
        checks++; if (reg_en !== 1'b1 || reg_wr_addr !== 32'h33 || gnt !== 1'b0) begin errors++; $display("FAIL mid_regrant got en=%b addr=%h gnt=%b exp 1/33/0", reg_en, reg_wr_addr, gnt); end
        reg_ack = 1'b1; rd_data = 32'h0000_3333;
        tick(1);
        reg_ack = 1'b0;
        checks++; if (r0_done !== 1'b1 || r0_rdata !== 32'h0000_3333) begin errors++; $display("FAIL mid_done got done=%b data=%h exp 1/00003333", r0_done, r0_rdata); end
        r0_req = 1'b0;
        tick(1);
    endtask

`ifdef DMI_REG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        // No ack: done after the 15th WAIT cycle, err=1, rdata forced to 0.
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h44;
        tick(2);   // ISSUE, WAIT cycle 1
        tick(14);  // WAIT cycle 15
        checks++; if (r0_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early got done=%b busy=%b exp 0/1", r0_done, busy); end
        tick(1);
        checks++; if (r0_done !== 1'b1 || r0_err !== 1'b1 || r0_rdata !== '0) begin errors++; $display("FAIL to_fire got done=%b err=%b data=%h exp 1/1/0", r0_done, r0_err, r0_rdata); end
        r0_req = 1'b0;
        tick(1);
        // Ack on the 15th WAIT cycle beats the timeout.
        r0_req = 1'b1;
        tick(2);
        tick(14);
        reg_ack = 1'b1; rd_data = 32'h5555_AAAA;
        tick(1);
        reg_ack = 1'b0;
        checks++; if (r0_done !== 1'b1 || r0_err !== 1'b0 || r0_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL to_ack_wins got done=%b err=%b data=%h exp 1/0/5555aaaa", r0_done, r0_err, r0_rdata); end
        r0_req = 1'b0;
        tick(1);
    endtask
`endif

    initial begin
        test_reset();
        test_port0_read();
        test_port1_write();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
`ifdef DMI_REG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
